// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: DMEM/MMIO decode, alignment faults, load/MMIO stall sequencing
// Optional MMIO wait timeout is compiled in when MMIO_TIMEOUT_EN is defined.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_width,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        dm_rd_en,
  output logic        dm_wrt_en,
  output logic [1:0]  dm_width,
  output logic        dm_unsigned,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wrt_data,
  input  logic [31:0] dm_rd_data,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {S_IDLE, S_DM_RD, S_IO_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_is_dmem, w_is_mmio, w_is_half, w_is_word, w_misaligned;
  logic        w_access, w_bad, w_idle, w_accept, w_dm_acc, w_io_acc;
  logic        w_timeout, w_io_done;
  logic        r_io_req, r_io_we, r_wb_valid, r_fault;
  logic [31:0] r_io_addr, r_io_wdata, r_wb_data, r_fault_addr;

  always_comb begin
    w_is_dmem    = (ex_addr[31:15] == 17'h0);
    w_is_mmio    = (ex_addr[31:28] == 4'hF);
    w_is_half    = (ex_width == 2'b01);
    w_is_word    = (ex_width == 2'b00) || (ex_width == 2'b11);
    w_misaligned = (w_is_half && ex_addr[0]) || (w_is_word && (ex_addr[1:0] != 2'b00));
    w_access     = ex_valid && (ex_load || ex_store);
    w_bad        = (ex_load && ex_store) || !(w_is_dmem || w_is_mmio) || w_misaligned ||
                   (w_is_mmio && !w_is_word);
    w_idle       = (r_state == S_IDLE);
    w_accept     = w_idle && w_access && !w_bad;
    w_dm_acc     = w_accept && w_is_dmem;
    w_io_acc     = w_accept && w_is_mmio;
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_to_cnt;

  // Fires in the TIMEOUT_CYCLES-th unacknowledged IO_WAIT cycle.
  assign w_timeout = (r_state == S_IO_WAIT) && !io_ack &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_io_acc) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IO_WAIT) && !io_ack) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign w_io_done = (r_state == S_IO_WAIT) && (io_ack || w_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dm_acc && ex_load) begin
          w_state_nxt = S_DM_RD;
        end else if (w_io_acc) begin
          w_state_nxt = S_IO_WAIT;
        end
      end
      S_DM_RD:   w_state_nxt = S_IDLE;
      S_IO_WAIT: if (w_io_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign dm_rd_en    = w_dm_acc && ex_load;
  assign dm_wrt_en   = w_dm_acc && ex_store;
  assign dm_width    = ex_width;
  assign dm_unsigned = ex_unsigned;
  assign dm_addr     = ex_addr;
  assign dm_wrt_data = ex_wdata;

  assign stall = ((r_state == S_IO_WAIT) && !io_ack && !w_timeout) ||
                 (w_dm_acc && ex_load) || w_io_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_req     <= 1'b0;
      r_io_we      <= 1'b0;
      r_io_addr    <= 32'h0;
      r_io_wdata   <= 32'h0;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= 32'h0;
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else begin
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      if (w_io_acc) begin
        r_io_req   <= 1'b1;
        r_io_we    <= ex_store;
        r_io_addr  <= ex_addr;
        r_io_wdata <= ex_wdata;
      end else if (w_io_done) begin
        r_io_req <= 1'b0;
      end
      if (r_state == S_DM_RD) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= dm_rd_data;
      end else if ((r_state == S_IO_WAIT) && io_ack && !r_io_we) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= io_rdata;
      end
      // Rejected requests are only recognised while IDLE; held ex_* elsewhere is ignored.
      if (w_idle && w_access && w_bad) begin
        r_fault      <= 1'b1;
        r_fault_addr <= ex_addr;
      end else if (w_timeout) begin
        r_fault      <= 1'b1;
        r_fault_addr <= r_io_addr;
      end
    end
  end

  assign io_req     = r_io_req;
  assign io_we      = r_io_we;
  assign io_addr    = r_io_addr;
  assign io_wdata   = r_io_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_data    = r_wb_data;
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule
